// File: rtl/w_mat_loader.sv
// Streams a weight matrix in row-major order, assembles each row of OUT_C weights
// and writes it to weight memory one row per strobe.
module w_mat_loader #(
  parameter int IN_C = 34,
  parameter int OUT_C = 32,
  parameter int W_WIDTH = 8,
  localparam int IN_C_WIDTH = (IN_C > 1) ? $clog2(IN_C) : 1,
  localparam int W_MEM_WIDTH = OUT_C * W_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      s_valid,
  input  logic signed [W_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic                      wr_en,
  output logic [IN_C_WIDTH-1:0]     wr_addr,
  output logic [W_MEM_WIDTH-1:0]    wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int LANE_W = (OUT_C > 1) ? $clog2(OUT_C) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                 state;
  logic [LANE_W-1:0]      lane;
  logic [IN_C_WIDTH-1:0]  row;
  logic [W_MEM_WIDTH-1:0] row_buf;
  logic [W_MEM_WIDTH-1:0] row_next;
  logic                   ready_r;
  logic                   wr_en_r;
  logic                   accept;

  // Abort masks the handshake and the write strobe in the very cycle it is raised.
  assign s_ready = ready_r && !abort;
  assign wr_en   = wr_en_r && !abort;
  assign accept  = s_ready && s_valid;

  always_comb begin
    row_next = row_buf;
    row_next[int'(lane)*W_WIDTH +: W_WIDTH] = s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lane    <= '0;
      row     <= '0;
      row_buf <= '0;
      ready_r <= 1'b0;
      wr_en_r <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            row     <= '0;
            lane    <= '0;
            ready_r <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            row     <= '0;
            lane    <= '0;
            ready_r <= 1'b0;
            busy    <= 1'b0;
          end else if (accept) begin
            row_buf <= row_next;
            if (lane == LANE_W'(OUT_C - 1)) begin
              // Row complete: publish it and hold it steady until the next write.
              lane    <= '0;
              state   <= WRITE;
              ready_r <= 1'b0;
              wr_en_r <= 1'b1;
              wr_addr <= row;
              wr_data <= row_next;
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en_r <= 1'b0;
          if (abort) begin
            state <= IDLE;
            row   <= '0;
            lane  <= '0;
            busy  <= 1'b0;
          end else if (row == IN_C_WIDTH'(IN_C - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            row     <= row + 1'b1;
            state   <= LOAD;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_mat_loader.sv
// Scoreboard bench for w_mat_loader: default 34x32x8 instance plus a 3x2x4 instance.
module tb_w_mat_loader;

  typedef struct {
    int           addr;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0]   s_data = '0;
  logic         s_ready, wr_en, busy, done;
  logic [5:0]   wr_addr;
  logic [255:0] wr_data;

  logic         start2 = 1'b0, abort2 = 1'b0, s_valid2 = 1'b0;
  logic [3:0]   s_data2 = '0;
  logic         s_ready2, wr_en2, busy2, done2;
  logic [1:0]   wr_addr2;
  logic [7:0]   wr_data2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   done_cnt2 = 0;
  exp_t q[$];
  exp_t q2[$];

  w_mat_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  w_mat_loader #(.IN_C(3), .OUT_C(2), .W_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .s_valid(s_valid2),
    .s_data(s_data2), .s_ready(s_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_row(input int base, input int r);
    logic [255:0] v;
    v = '0;
    for (int l = 0; l < 32; l++) v[l*8 +: 8] = 8'(base + r*32 + l);
    return v;
  endfunction

  // Monitors: every write strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        chk("wr_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (done) done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en2) begin
        chk("small_wr_expected", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          exp_t e;
          e = q2.pop_front();
          chk("small_wr_addr", wr_addr2, e.addr);
          chk("small_wr_data", wr_data2, e.data);
        end
      end
      if (done2) done_cnt2++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic run_load(input int base, input int exp_rows, input bit toggle,
                          input int restart_at, input int abort_words,
                          input int rst_row, input int exp_lat);
    int idx, d0, st_cyc;
    bit seen;
    for (int r = 0; r < exp_rows; r++) q.push_back('{r, exp_row(base, r)});
    d0 = done_cnt;
    idx = 0;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b0;
    st_cyc = cyc;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      start = (restart_at >= 0) && (cyc - st_cyc == restart_at);
      s_valid = !toggle || (k % 2 == 0);
      s_data = 8'(base + idx);
      abort = (abort_words >= 0) && (idx == abort_words);
      #1;
      if (abort) begin
        @(posedge clk);
        #1;
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue_drained", q.size(), 0);
        return;
      end
      if (s_valid && s_ready) idx++;
      if (rst_row >= 0 && idx == (rst_row + 1) * 32) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("rst_pre_wr_en", wr_en, 1);
        chk("rst_pre_addr", wr_addr, rst_row);
        rst = 1'b1;
        #1;
        check_reset_outputs("midwrite_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_queue_drained", q.size(), 0);
        chk("rst_no_done", done_cnt, d0);
        return;
      end
      if (done) begin
        seen = 1;
        if (exp_lat >= 0) chk("done_latency", cyc - st_cyc, exp_lat);
      end
    end
    s_valid = 1'b0;
    chk("done_seen", seen, 1);
    @(negedge clk);
    #1;
    chk("done_count", done_cnt, d0 + 1);
    chk("queue_drained", q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int idx, st;
    bit seen;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("idle");

    // Small config; start and abort together in IDLE, start must win.
    q2.push_back('{0, 256'h21});
    q2.push_back('{1, 256'h43});
    q2.push_back('{2, 256'h65});
    @(negedge clk);
    start2 = 1'b1;
    abort2 = 1'b1;
    st = cyc;
    idx = 0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      abort2 = 1'b0;
      s_valid2 = 1'b1;
      s_data2 = 4'(idx + 1);
      #1;
      if (s_valid2 && s_ready2) idx++;
      if (done2) begin
        seen = 1;
        chk("small_done_latency", cyc - st, 10);
      end
    end
    s_valid2 = 1'b0;
    chk("small_done_seen", seen, 1);
    chk("small_queue_drained", q2.size(), 0);
    chk("small_done_count", done_cnt2, 1);

    run_load(0, 34, 0, -1, -1, -1, 1123);
    run_load(0, 34, 1, -1, -1, -1, -1);
    run_load(0, 34, 0, 50, -1, -1, 1123);
    run_load(0, 5, 0, -1, 5*32 + 10, -1, -1);
    run_load(128, 34, 0, -1, -1, -1, 1123);
    run_load(0, 2, 0, -1, -1, 2, -1);
    run_load(7, 34, 0, -1, -1, -1, 1123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
